peak_dpu_ex_br: RTL

PEAK_DPU_EX_BR -- requirements
Module: peak_dpu_ex_br

---
 rtl/peak_dpu_ex_br.sv | 119 +++++++++++
 1 files changed

// File: rtl/peak_dpu_ex_br.sv
// rtl/peak_dpu_ex_br.sv - branch/jump execute unit with fetch-redirect handshake
// Optional PEAK_DPU_BR_PERF_CNT_EN adds saturating branch/taken counters.
module peak_dpu_ex_br (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_vld,
   output logic        ex_rdy,
   input  logic [2:0]  ex_br_op,
   input  logic [31:0] ex_pc,
   input  logic        ex_is_compressed,
   input  logic [31:0] ex_rs1_data,
   input  logic [31:0] ex_rs2_data,
   input  logic [31:0] ex_imm,
   input  logic        ex_use_imm,
   input  logic        ex_wr_vld,
   input  logic [4:0]  ex_wr_addr,
   output logic        wb_vld,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        redirect_vld,
   output logic [31:0] redirect_pc,
   input  logic        redirect_rdy,
   output logic        br_kill
`ifdef PEAK_DPU_BR_PERF_CNT_EN
   ,
   output logic [31:0] perf_br_cnt,
   output logic [31:0] perf_taken_cnt
`endif
);

   localparam logic [2:0] OP_JAL  = 3'd0;
   localparam logic [2:0] OP_JALR = 3'd1;
   localparam logic [2:0] OP_BEQ  = 3'd2;
   localparam logic [2:0] OP_BNE  = 3'd3;
   localparam logic [2:0] OP_BLT  = 3'd4;
   localparam logic [2:0] OP_BGE  = 3'd5;
   localparam logic [2:0] OP_BLTU = 3'd6;

   typedef enum logic {IDLE = 1'b0, RDR = 1'b1} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        taken;
   logic [31:0] target;
   logic [31:0] jalr_sum;
   logic [31:0] link;

   assign accept = ex_vld && ex_rdy;

   always_comb begin
      taken = 1'b0;
      case (ex_br_op)
         OP_JAL, OP_JALR: taken = 1'b1;
         OP_BEQ:          taken = (ex_rs1_data == ex_rs2_data);
         OP_BNE:          taken = (ex_rs1_data != ex_rs2_data);
         OP_BLT:          taken = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
         OP_BGE:          taken = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
         OP_BLTU:         taken = (ex_rs1_data <  ex_rs2_data);
         default:         taken = (ex_rs1_data >= ex_rs2_data);
      endcase
   end

   // JALR clears bit 0 of the computed address; all other kinds are pc-relative.
   assign jalr_sum = ex_rs1_data + (ex_use_imm ? ex_imm : 32'd0);
   assign target   = (ex_br_op == OP_JALR) ? {jalr_sum[31:1], 1'b0} : (ex_pc + ex_imm);
   assign link     = ex_pc + (ex_is_compressed ? 32'd2 : 32'd4);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && taken) state_nxt = RDR;
         RDR:     if (redirect_rdy)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ex_rdy       = (state == IDLE);
      redirect_vld = (state == RDR);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_vld      <= 1'b0;
         wb_addr     <= 5'd0;
         wb_data     <= 32'd0;
         redirect_pc <= 32'd0;
         br_kill     <= 1'b0;
      end else begin
         wb_vld  <= accept && ex_wr_vld && (ex_wr_addr != 5'd0);
         br_kill <= accept && taken;
         if (accept) begin
            wb_addr <= ex_wr_addr;
            wb_data <= link;
         end
         // Only a taken branch updates the target so it stays stable throughout RDR.
         if (accept && taken) redirect_pc <= target;
      end
   end

`ifdef PEAK_DPU_BR_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_br_cnt    <= 32'd0;
         perf_taken_cnt <= 32'd0;
      end else if (accept) begin
         if (perf_br_cnt != 32'hFFFF_FFFF) perf_br_cnt <= perf_br_cnt + 32'd1;
         if (taken && (perf_taken_cnt != 32'hFFFF_FFFF)) perf_taken_cnt <= perf_taken_cnt + 32'd1;
      end
   end
`endif

endmodule
